// File: rtl/baud_tick_gen_frac.sv
// UART baud tick generator: fractional divisor, oversample tick and bit tick, glitch-free reload.
// Fractional accumulator is built only when BAUD_FRAC_EN is defined; otherwise every period is eff_int clocks.
module baud_tick_gen_frac #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OVS          = 16,
    parameter int DEFAULT_INT  = 651,
    parameter int DEFAULT_FRAC = 0,
    localparam int PH_W        = $clog2(OVS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              resync,
    input  logic              div_load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              rx_tick,
    output logic              tx_tick,
    output logic [PH_W-1:0]   phase,
    output logic              load_pend
);

    logic [DIV_W:0]    cnt;
    logic [DIV_W:0]    eff_int;
    logic [DIV_W:0]    per_m1;
    logic [DIV_W-1:0]  int_r;
    logic [DIV_W-1:0]  sh_int;
    logic [PH_W-1:0]   phase_r;
    logic              ext;
    logic              tick;
    logic              apply;

    assign eff_int = (int_r == '0) ? (DIV_W+1)'(1) : {1'b0, int_r};
    assign per_m1  = ext ? eff_int : eff_int - (DIV_W+1)'(1);

    assign tick      = en & ~resync & (cnt == per_m1);
    assign apply     = load_pend & (tick | ~en | resync);
    assign rx_tick   = tick;
    assign tx_tick   = tick & (phase_r == PH_W'(OVS-1));
    assign phase     = phase_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            phase_r   <= '0;
            int_r     <= DIV_W'(DEFAULT_INT);
            sh_int    <= '0;
            load_pend <= 1'b0;
        end else begin
            if (resync) begin
                cnt     <= '0;
                phase_r <= '0;
            end else if (tick) begin
                cnt     <= '0;
                phase_r <= (phase_r == PH_W'(OVS-1)) ? '0 : phase_r + PH_W'(1);
            end else if (en) begin
                cnt     <= cnt + (DIV_W+1)'(1);
            end

            // A strobe landing on a boundary re-arms the shadow; the older shadow still applies now.
            if (div_load) begin
                sh_int    <= div_int;
                load_pend <= 1'b1;
            end else if (apply) begin
                load_pend <= 1'b0;
            end
            if (apply)
                int_r <= sh_int;
        end
    end

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] frac_r;
    logic [FRAC_W-1:0] sh_frac;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc} + {1'b0, frac_r};

    // Carry out of the accumulator stretches the following period by one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            ext     <= 1'b0;
            frac_r  <= FRAC_W'(DEFAULT_FRAC);
            sh_frac <= '0;
        end else begin
            if (resync) begin
                acc <= '0;
                ext <= 1'b0;
            end else if (tick) begin
                acc <= acc_sum[FRAC_W-1:0];
                ext <= acc_sum[FRAC_W];
            end
            if (div_load)
                sh_frac <= div_frac;
            if (apply)
                frac_r <= sh_frac;
        end
    end
`else
    logic unused_frac;
    assign unused_frac = ^div_frac;
    assign ext         = 1'b0;
`endif

endmodule

// File: tb/tb_baud_tick_gen_frac.sv
// Scoreboard bench for baud_tick_gen_frac: stimulus queues expected ticks, a negedge monitor checks them.
module tb_baud_tick_gen_frac;
    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OVS    = 16;
    localparam int PH_W   = 4;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              en       = 1'b0;
    logic              resync   = 1'b0;
    logic              div_load = 1'b0;
    logic [DIV_W-1:0]  div_int  = '0;
    logic [FRAC_W-1:0] div_frac = '0;
    logic              rx_tick;
    logic              tx_tick;
    logic [PH_W-1:0]   phase;
    logic              load_pend;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int   cyc;
        logic tx;
        int   ph;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    baud_tick_gen_frac #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS),
        .DEFAULT_INT(5), .DEFAULT_FRAC(0)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .resync(resync),
        .div_load(div_load), .div_int(div_int), .div_frac(div_frac),
        .rx_tick(rx_tick), .tx_tick(tx_tick), .phase(phase), .load_pend(load_pend)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at cyc=%0d", name, act, req, cyc);
        end
    endtask

    task automatic expect_tick(input int c, input int n);
        exp_t e;
        e.cyc = c;
        e.ph  = n % OVS;
        e.tx  = ((n % OVS) == OVS - 1);
        q.push_back(e);
    endtask

    // Monitor: every presented rx_tick must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && tx_tick)
            chk("tx_implies_rx", int'(rx_tick), 1);
        if (!reset && rx_tick) begin
            if (q.size() == 0) begin
                chk("unexpected_tick", int'(rx_tick), 0);
            end else begin
                mon_e = q.pop_front();
                chk("tick_cyc", cyc, mon_e.cyc);
                chk("tick_phase", int'(phase), mon_e.ph);
                chk("tick_tx", int'(tx_tick), int'(mon_e.tx));
            end
        end
    end

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", q.size(), 0);
        q.delete();
    endtask

    task automatic do_reset(output int c0);
        reset    = 1'b1;
        en       = 1'b1;
        resync   = 1'b0;
        div_load = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_rx", int'(rx_tick), 0);
        chk("rst_tx", int'(tx_tick), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_pend", int'(load_pend), 0);
        reset = 1'b0;
        c0    = cyc;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int t;
        @(posedge clk); #1;

        // Default divisor 5: first tick in 5th cycle, tx every 80 clocks
        do_reset(c0);
        for (int n = 0; n < 20; n++) expect_tick(c0 + 4 + 5*n, n);
        drain(200);

        // Reload to 3 mid-period: old period completes, then 3-clock periods
        do_reset(c0);
        expect_tick(c0 + 4, 0);
        expect_tick(c0 + 9, 1);
        for (int k = 2; k < 18; k++) expect_tick(c0 + 9 + 3*(k-1), k);
        goto(c0 + 6); div_int = 3; div_load = 1'b1;
        goto(c0 + 7); div_load = 1'b0;
        chk("pend_set", int'(load_pend), 1);
        goto(c0 + 9);
        chk("pend_at_tick", int'(load_pend), 1);
        goto(c0 + 10);
        chk("pend_cleared", int'(load_pend), 0);
        drain(200);

        // Resync at phase 7, cnt 2
        do_reset(c0);
        for (int n = 0; n < 7; n++) expect_tick(c0 + 4 + 5*n, n);
        for (int m = 0; m < 17; m++) expect_tick(c0 + 42 + 5*m, m);
        goto(c0 + 37);
        chk("phase_before_resync", int'(phase), 7);
        resync = 1'b1;
        goto(c0 + 38); resync = 1'b0;
        goto(c0 + 43);
        chk("phase_after_resync_tick", int'(phase), 1);
        drain(300);

        // en low for 10 clocks mid-period
        do_reset(c0);
        expect_tick(c0 + 4, 0);
        for (int n = 1; n < 4; n++) expect_tick(c0 + 19 + 5*(n-1), n);
        goto(c0 + 7); en = 1'b0;
        goto(c0 + 12);
        chk("hold_phase", int'(phase), 1);
        chk("hold_no_tick", int'(rx_tick), 0);
        goto(c0 + 17); en = 1'b1;
        drain(100);

        // div_int = 0 behaves as 1: tick every clock
        do_reset(c0);
        expect_tick(c0 + 4, 0);
        expect_tick(c0 + 9, 1);
        for (int n = 2; n < 22; n++) expect_tick(c0 + 8 + n, n);
        goto(c0 + 5); div_int = 0; div_load = 1'b1;
        goto(c0 + 6); div_load = 1'b0;
        drain(100);

        // Async reset mid-period with a pending load
        do_reset(c0);
        expect_tick(c0 + 4, 0);
        expect_tick(c0 + 9, 1);
        goto(c0 + 10); div_int = 0; div_load = 1'b1;
        goto(c0 + 11); div_load = 1'b0;
        goto(c0 + 14);
        chk("pre_rst_tick", int'(rx_tick), 1);
        chk("pre_rst_pend", int'(load_pend), 1);
        chk("pre_rst_phase", int'(phase), 2);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_rx", int'(rx_tick), 0);
        chk("async_rst_phase", int'(phase), 0);
        chk("async_rst_pend", int'(load_pend), 0);
        chk("async_rst_queue", q.size(), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        c0 = cyc;
        for (int n = 0; n < 4; n++) expect_tick(c0 + 4 + 5*n, n);
        drain(100);

`ifdef BAUD_FRAC_EN
        // int=4 frac=4: every 4th period after the first four is 5 clocks
        do_reset(c0);
        expect_tick(c0 + 4, 0);
        expect_tick(c0 + 9, 1);
        t = c0 + 9;
        for (int j = 1; j <= 20; j++) begin
            t += (j > 1 && (j % 4) == 1) ? 5 : 4;
            expect_tick(t, j + 1);
        end
        goto(c0 + 5); div_int = 4; div_frac = 4; div_load = 1'b1;
        goto(c0 + 6); div_load = 1'b0;
        drain(200);
`else
        t = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
